// File: rtl/kfpga_config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kfpga_config_pkg
// Description : Shared definitions for the IO tile configuration loader:
//               loader FSM state encoding, default widths and a chain-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package kfpga_config_pkg;

  localparam int DEFAULT_CONFIG_WIDTH = 24;
  localparam int DEFAULT_COUNT_WIDTH  = 5;

  // Loader state: how much of the current frame the chain holds
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } cfg_state_t;

  // Chain length: one extra bit when the frame carries a parity bit
  function automatic int chain_width(input int config_width, input bit parity_en);
    return parity_en ? config_width + 1 : config_width;
  endfunction

endpackage : kfpga_config_pkg
`default_nettype wire

// File: rtl/config_shift_chain.sv
`default_nettype none
// ============================================================================
// Module      : config_shift_chain
// Description : Serial configuration shift chain with a saturating bit
//               counter. Shifting continues after the counter saturates so
//               the chain always holds the most recent CHAIN_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module config_shift_chain
  import kfpga_config_pkg::*;
#(
  parameter int CHAIN_W     = DEFAULT_CONFIG_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic                   shift_in,
  input  logic                   count_clear,
  output logic [CHAIN_W-1:0]     chain,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(CHAIN_W);

  // Shift one bit in at the LSB per enabled cycle; MSB falls out to the next tile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (shift_en) begin
      chain <= {chain[CHAIN_W-2:0], shift_in};
    end
  end

  // Count accepted bits, saturating at a full frame; cleared by an accepted commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count_clear) begin
      count <= '0;
    end else if (shift_en && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule : config_shift_chain
`default_nettype wire

// File: rtl/io_tile_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : io_tile_config_loader
// Description : IO tile configuration loader. Serial bits are shifted into a
//               chain; a commit on a complete frame copies the chain into the
//               shadow register that drives the IO tile. Commits on an
//               incomplete frame, or together with a shift, are rejected and
//               set a sticky error flag.
//               Build option: define KFPGA_CONFIG_PARITY_EN to append an even
//               parity bit to each frame and reject commits that fail it.
// Revision    : 1.0 - initial release
// ============================================================================
module io_tile_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                    config_clock,
  input  logic                    config_reset,
  input  logic                    config_in,
  input  logic                    config_enable,
  input  logic                    config_commit,
  output logic                    config_out,
  output logic [CONFIG_WIDTH-1:0] config_data,
  output logic                    config_full,
  output logic                    config_valid,
  output logic                    config_error
);

`ifdef KFPGA_CONFIG_PARITY_EN
  localparam int CHAIN_W = chain_width(CONFIG_WIDTH, 1'b1);
`else
  localparam int CHAIN_W = chain_width(CONFIG_WIDTH, 1'b0);
`endif

  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(CHAIN_W - 1);

  logic [CHAIN_W-1:0]      chain;
  logic [COUNT_WIDTH-1:0]  count;
  cfg_state_t              state;
  cfg_state_t              state_next;
  logic                    parity_ok;
  logic [CONFIG_WIDTH-1:0] frame_data;
  logic                    commit_accept;
  logic                    commit_reject;

  config_shift_chain #(
    .CHAIN_W     (CHAIN_W),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_chain (
    .clk         (config_clock),
    .rst         (config_reset),
    .shift_en    (config_enable),
    .shift_in    (config_in),
    .count_clear (commit_accept),
    .chain       (chain),
    .count       (count)
  );

`ifdef KFPGA_CONFIG_PARITY_EN
  // Last bit shifted is the parity bit; the whole frame must XOR to zero
  assign parity_ok  = ~(^chain);
  assign frame_data = chain[CHAIN_W-1:1];
`else
  assign parity_ok  = 1'b1;
  assign frame_data = chain;
`endif

  // A commit succeeds only on a complete, parity-clean frame with no shift in flight
  assign commit_accept = config_commit && !config_enable && (state == FULL) && parity_ok;
  assign commit_reject = config_commit && !commit_accept;

  assign config_out  = chain[CHAIN_W-1];
  assign config_full = (state == FULL);

  // Loader state register
  always_ff @(posedge config_clock or posedge config_reset) begin
    if (config_reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: track frame fill level; an accepted commit empties the frame
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (config_enable) begin
          state_next = LOADING;
        end
      end
      LOADING: begin
        if (config_enable && (count == COUNT_LAST)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        state_next = FULL;
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (commit_accept) begin
      state_next = EMPTY;
    end
  end

  // Shadow register and status flags; data only moves on an accepted commit
  always_ff @(posedge config_clock or posedge config_reset) begin
    if (config_reset) begin
      config_data  <= '0;
      config_valid <= 1'b0;
      config_error <= 1'b0;
    end else begin
      if (commit_accept) begin
        config_data  <= frame_data;
        config_valid <= 1'b1;
      end
      if (commit_reject) begin
        config_error <= 1'b1;
      end
    end
  end

endmodule : io_tile_config_loader
`default_nettype wire

// File: tb/tb_io_tile_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_tile_config_loader
// Description : Self-checking bench for io_tile_config_loader. A behavioural
//               model of the loader is stepped alongside the DUT; committed
//               data is queued when a commit is driven and compared when the
//               DUT updates. Directed sequences cover the main frame load,
//               rejected commits, saturation/replay, parity and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_tile_config_loader;

  localparam int CW = 24;
  localparam int NW = 5;
`ifdef KFPGA_CONFIG_PARITY_EN
  localparam int CHAIN_W = CW + 1;
`else
  localparam int CHAIN_W = CW;
`endif

  logic          clk = 1'b0;
  logic          config_reset;
  logic          config_in;
  logic          config_enable;
  logic          config_commit;
  logic          config_out;
  logic [CW-1:0] config_data;
  logic          config_full;
  logic          config_valid;
  logic          config_error;

  io_tile_config_loader #(
    .CONFIG_WIDTH (CW),
    .COUNT_WIDTH  (NW)
  ) dut (
    .config_clock  (clk),
    .config_reset  (config_reset),
    .config_in     (config_in),
    .config_enable (config_enable),
    .config_commit (config_commit),
    .config_out    (config_out),
    .config_data   (config_data),
    .config_full   (config_full),
    .config_valid  (config_valid),
    .config_error  (config_error)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [CHAIN_W-1:0] m_chain;
  int                 m_count;
  logic [CW-1:0]      m_data;
  logic               m_valid;
  logic               m_error;
  logic [CW-1:0]      sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_parity_ok(input logic [CHAIN_W-1:0] c);
`ifdef KFPGA_CONFIG_PARITY_EN
    return ~(^c);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [CW-1:0] model_data(input logic [CHAIN_W-1:0] c);
`ifdef KFPGA_CONFIG_PARITY_EN
    return c[CHAIN_W-1:1];
`else
    return c[CW-1:0];
`endif
  endfunction

  function automatic logic [CHAIN_W-1:0] make_frame(input logic [CW-1:0] d);
`ifdef KFPGA_CONFIG_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_chain = '0;
    m_count = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_error = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_outputs();
    check("out",   {31'd0, config_out},   {31'd0, m_chain[CHAIN_W-1]});
    check("full",  {31'd0, config_full},  {31'd0, (m_count == CHAIN_W)});
    check("valid", {31'd0, config_valid}, {31'd0, m_valid});
    check("error", {31'd0, config_error}, {31'd0, m_error});
    check("data",  {8'd0, config_data},   {8'd0, m_data});
  endtask

  // Drive one clock cycle of stimulus, advance the model, then check the DUT
  task automatic cycle(input logic en, input logic din, input logic cm);
    logic          accept;
    logic [CW-1:0] exp_d;
    config_enable = en;
    config_in     = din;
    config_commit = cm;
    accept = cm && !en && (m_count == CHAIN_W) && model_parity_ok(m_chain);
    if (cm && !accept) m_error = 1'b1;
    if (accept) begin
      m_data  = model_data(m_chain);
      m_valid = 1'b1;
      m_count = 0;
    end
    if (en) begin
      m_chain = {m_chain[CHAIN_W-2:0], din};
      if (m_count < CHAIN_W) m_count++;
    end
    if (cm) sb_q.push_back(m_data);
    @(posedge clk);
    #1;
    config_enable = 1'b0;
    config_in     = 1'b0;
    config_commit = 1'b0;
    if (cm) begin
      exp_d = sb_q.pop_front();
      check("commit_data", {8'd0, config_data}, {8'd0, exp_d});
    end
    check_outputs();
  endtask

  task automatic shift_frame(input logic [CHAIN_W-1:0] f);
    for (int i = CHAIN_W - 1; i >= 0; i--) cycle(1'b1, f[i], 1'b0);
  endtask

  // Assert reset between clock edges and confirm outputs clear without a clock
  task automatic do_reset();
    @(posedge clk);
    #3;
    config_reset = 1'b1;
    #1;
    check("rst_out",   {31'd0, config_out},   32'd0);
    check("rst_data",  {8'd0, config_data},   32'd0);
    check("rst_full",  {31'd0, config_full},  32'd0);
    check("rst_valid", {31'd0, config_valid}, 32'd0);
    check("rst_error", {31'd0, config_error}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    config_reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [CHAIN_W-1:0] f;
    logic               bits[1:30];
    logic [CW-1:0]      exp_d;
    logic               p;

    config_reset  = 1'b1;
    config_in     = 1'b0;
    config_enable = 1'b0;
    config_commit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_data",  {8'd0, config_data},   32'd0);
    check("por_full",  {31'd0, config_full},  32'd0);
    check("por_valid", {31'd0, config_valid}, 32'd0);
    check("por_error", {31'd0, config_error}, 32'd0);
    check("por_out",   {31'd0, config_out},   32'd0);
    config_reset = 1'b0;
    @(posedge clk);
    #1;

    // Main frame load and commit
    shift_frame(make_frame(24'hA5C3F0));
    check("load_full", {31'd0, config_full}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("load_data",  {8'd0, config_data},   32'hA5C3F0);
    check("load_valid", {31'd0, config_valid}, 32'd1);
    check("load_full0", {31'd0, config_full},  32'd0);

    // Commit on a partial frame is rejected, count is kept
    do_reset();
    f = make_frame(24'h3C5A96);
    for (int i = CHAIN_W - 1; i >= CHAIN_W - 10; i--) cycle(1'b1, f[i], 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("partial_err",  {31'd0, config_error}, 32'd1);
    check("partial_data", {8'd0, config_data},   32'd0);
    check("partial_full", {31'd0, config_full},  32'd0);
    for (int i = CHAIN_W - 11; i >= 1; i--) cycle(1'b1, f[i], 1'b0);
    check("partial_notfull", {31'd0, config_full}, 32'd0);
    cycle(1'b1, f[0], 1'b0);
    check("partial_nowfull", {31'd0, config_full}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("sticky_data", {8'd0, config_data},   32'h3C5A96);
    check("sticky_err",  {31'd0, config_error}, 32'd1);

    // Commit together with a shift: shift happens, commit rejected
    do_reset();
    shift_frame(make_frame(24'h123456));
    cycle(1'b0, 1'b0, 1'b1);
    check("pre_both_data", {8'd0, config_data}, 32'h123456);
    shift_frame(make_frame(24'h0F0F0F));
    cycle(1'b1, 1'b1, 1'b1);
    check("both_err",  {31'd0, config_error}, 32'd1);
    check("both_data", {8'd0, config_data},   32'h123456);
    check("both_full", {31'd0, config_full},  32'd1);

    // Overshift: counter saturates, MSB replays the oldest bits
    do_reset();
    for (int k = 1; k <= 30; k++) bits[k] = 1'($urandom_range(0, 1));
`ifdef KFPGA_CONFIG_PARITY_EN
    p = 1'b0;
    for (int k = 31 - CHAIN_W; k <= 29; k++) p = p ^ bits[k];
    bits[30] = p;
`else
    p = 1'b0;
`endif
    for (int k = 1; k <= 30; k++) begin
      if (k > CHAIN_W) check("replay", {31'd0, config_out}, {31'd0, bits[k - CHAIN_W]});
      cycle(1'b1, bits[k], 1'b0);
    end
    check("sat_full", {31'd0, config_full}, 32'd1);
    for (int j = 0; j < CW; j++) exp_d[CW - 1 - j] = bits[31 - CHAIN_W + j];
    cycle(1'b0, 1'b0, 1'b1);
    check("sat_data", {8'd0, config_data}, {8'd0, exp_d});

`ifdef KFPGA_CONFIG_PARITY_EN
    // Bad parity is rejected and the frame stays full; good parity commits
    do_reset();
    shift_frame({24'hFFFFFF, 1'b1});
    cycle(1'b0, 1'b0, 1'b1);
    check("par_bad_err",  {31'd0, config_error}, 32'd1);
    check("par_bad_data", {8'd0, config_data},   32'd0);
    check("par_bad_full", {31'd0, config_full},  32'd1);
    shift_frame({24'hFFFFFF, 1'b0});
    cycle(1'b0, 1'b0, 1'b1);
    check("par_ok_data", {8'd0, config_data}, 32'hFFFFFF);
`endif

    // Reset in the middle of a load discards the partial frame
    do_reset();
    f = make_frame(24'hFFF000);
    for (int i = CHAIN_W - 1; i >= CHAIN_W - 12; i--) cycle(1'b1, f[i], 1'b0);
    do_reset();
    shift_frame(make_frame(24'h5A0F3C));
    check("after_rst_full", {31'd0, config_full}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("after_rst_data", {8'd0, config_data}, 32'h5A0F3C);
    check("after_rst_err",  {31'd0, config_error}, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 8));
    end
    for (int n = 0; n < 6; n++) begin
      shift_frame(make_frame(CW'($urandom())));
      cycle(1'b0, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_io_tile_config_loader
`default_nettype wire

// File: doc/io_tile_config_loader.md
IO_TILE_CONFIG_LOADER -- requirements
Module: io_tile_config_loader

Interface
REQ-001 The block SHALL have parameter CONFIG_WIDTH, default 24: number of configuration bits delivered to the IO tile.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 5: counter width, at least clog2(CONFIG_WIDTH+2).
REQ-003 config_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 config_reset  input  1  asynchronous, active-high reset.
REQ-005 config_in  input  1  serial configuration bit.
REQ-006 config_enable  input  1  shift strobe; one bit is accepted per cycle while high.
REQ-007 config_commit  input  1  request to transfer the shift chain into the active register.
REQ-008 config_out  output  1  chain MSB, for daisy-chaining to the next tile.
REQ-009 config_data  output  CONFIG_WIDTH  active (shadow) configuration driven to the IO tile.
REQ-010 config_full  output  1  high when the chain holds a complete frame.
REQ-011 config_valid  output  1  high once at least one commit has succeeded.
REQ-012 config_error  output  1  sticky flag for a rejected commit.

Function
REQ-013 The chain register SHALL have CHAIN_W bits: CONFIG_WIDTH, or CONFIG_WIDTH+1 with parity (REQ-026).
REQ-014 When config_enable=1, the chain SHALL update to {chain[CHAIN_W-2:0], config_in}.
REQ-015 config_out SHALL equal chain[CHAIN_W-1] directly from the register, with no combinational path from config_in.
REQ-016 The bit counter SHALL increment on each enabled cycle and saturate at CHAIN_W; shifting continues past saturation.
REQ-017 The FSM SHALL have states EMPTY (count=0), LOADING (0<count<CHAIN_W) and FULL (count=CHAIN_W).
- Transitions: EMPTY->LOADING on enable; LOADING->FULL on the CHAIN_W-th enable; FULL stays FULL on enable.
- Any state->EMPTY on an accepted commit.
REQ-018 config_full SHALL be high exactly in state FULL.
REQ-019 A commit SHALL be accepted only in FULL with config_enable=0.
- One cycle later: config_data holds the data bits of the chain, config_valid=1, count=0.
- The chain contents are retained.
REQ-020 A commit in EMPTY or LOADING SHALL be rejected: config_error=1, config_data unchanged, count unchanged.
REQ-021 When commit and enable are high in the same cycle, the shift SHALL occur, the commit SHALL be rejected and config_error=1.
REQ-022 config_data SHALL never change except on an accepted commit or on reset.
REQ-023 config_error SHALL stay set until reset; later commits still execute normally.

Reset
REQ-024 On reset assertion, asynchronously: chain=0, count=0, state=EMPTY, config_data=0, config_full=0, config_valid=0, config_error=0, config_out=0.
REQ-025 A reset asserted mid-load SHALL discard the partial frame; the next frame starts from count 0.

Configuration
REQ-026 Macro KFPGA_CONFIG_PARITY_EN SHALL select frame parity.
- Defined: CHAIN_W=CONFIG_WIDTH+1; the last bit shifted (chain[0]) is a parity bit. A FULL commit is accepted only if the XOR of all CHAIN_W bits is 0 (even parity); on mismatch, config_error=1, config_data unchanged, state stays FULL. config_data takes chain[CHAIN_W-1:1].
- Undefined: CHAIN_W=CONFIG_WIDTH, no parity check, config_data takes chain[CONFIG_WIDTH-1:0].

Structure
REQ-027 Package kfpga_config_pkg SHALL hold the FSM state enumeration (EMPTY, LOADING, FULL) and the default width constants.
REQ-028 The shift chain plus counter SHALL be a sub-module config_shift_chain; the FSM, commit logic, shadow register and parity check SHALL stay in the top.

Verification
REQ-029 Reset, then shift 24 bits of 0xA5C3F0 MSB-first, then commit -> config_full=1 after bit 24; the cycle after commit config_data=0xA5C3F0, config_valid=1, config_full=0.
REQ-030 Shift 10 bits, then commit -> config_error=1, config_data=0, state LOADING, count=10.
REQ-031 With FULL, assert commit and enable together -> shift occurs, config_error=1, config_data unchanged.
REQ-032 Shift 30 bits into width 24 -> count saturates at 24; config_out replays bits 1..6 on cycles 25..30; commit loads the last 24 bits.
REQ-033 With parity on, shift 0xFFFFFF plus parity 1 -> commit rejected, error=1; reshift with parity 0 and commit -> config_data=0xFFFFFF.
REQ-034 Assert reset at bit 12 of a load -> all outputs 0 immediately; a following 24-bit load and commit succeeds.
